// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM states,
// base opcodes, one-hot instruction classes and datapath mux encodings.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Bit positions inside the one-hot class vector
    localparam int CLS_OP       = 0;
    localparam int CLS_OP_IMM   = 1;
    localparam int CLS_LOAD     = 2;
    localparam int CLS_STORE    = 3;
    localparam int CLS_BRANCH   = 4;
    localparam int CLS_JAL      = 5;
    localparam int CLS_JALR     = 6;
    localparam int CLS_LUI      = 7;
    localparam int CLS_AUIPC    = 8;
    localparam int CLS_MISC_MEM = 9;
    localparam int CLS_SYSTEM   = 10;
    localparam int NUM_CLS      = 11;

    typedef logic [NUM_CLS-1:0] op_class_t;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JALR = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port handshake shared by instruction fetch and load/store.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_is_data;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output mem_is_data, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_is_data, output mem_ack);
endinterface

// File: rtl/opcode_classify.sv
// Combinational RV32I base-opcode classifier: one-hot class plus a valid flag.
module opcode_classify
    import core_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       valid
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_OP:       cls[CLS_OP]       = 1'b1;
            OPC_OP_IMM:   cls[CLS_OP_IMM]   = 1'b1;
            OPC_LOAD:     cls[CLS_LOAD]     = 1'b1;
            OPC_STORE:    cls[CLS_STORE]    = 1'b1;
            OPC_BRANCH:   cls[CLS_BRANCH]   = 1'b1;
            OPC_JAL:      cls[CLS_JAL]      = 1'b1;
            OPC_JALR:     cls[CLS_JALR]     = 1'b1;
            OPC_LUI:      cls[CLS_LUI]      = 1'b1;
            OPC_AUIPC:    cls[CLS_AUIPC]    = 1'b1;
            OPC_MISC_MEM: cls[CLS_MISC_MEM] = 1'b1;
            OPC_SYSTEM:   cls[CLS_SYSTEM]   = 1'b1;
            default:      cls = '0;
        endcase
        valid = |cls;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath,
// arbitrating the unified memory port and counting retired instructions.
module multicycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_ctrl_if.master        mem,
    input  logic [6:0]               ir_opcode,
    input  logic                     branch_taken,
    output logic                     ir_we,
    output logic                     mdr_we,
    output logic                     pc_we,
    output logic [1:0]               pc_src,
    output logic                     rf_we,
    output logic [1:0]               wb_sel,
    output logic                     alu_src_a,
    output logic                     alu_src_b,
    output logic                     alu_use_dec,
    output logic [31:0]              reset_pc,
    output logic                     halted,
    output logic                     illegal,
    output logic [31:0]              instret
);

    state_t    state;
    state_t    state_next;
    op_class_t cls;
    logic      cls_valid;
    logic      halt_set;
    logic      illegal_set;
    logic      halted_q;
    logic      illegal_q;
    logic [31:0] instret_q;

    assign reset_pc = RESET_PC;

    // The IR is stable from DECODE onward, so classify it live every cycle
    opcode_classify u_classify (
        .opcode (ir_opcode),
        .cls    (cls),
        .valid  (cls_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state <= state_next;
            if (halt_set) begin
                halted_q  <= 1'b1;
                illegal_q <= illegal_set;
            end
            if (pc_we) instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        state_next      = state;
        mem.mem_req     = 1'b0;
        mem.mem_we      = 1'b0;
        mem.mem_is_data = 1'b0;
        ir_we           = 1'b0;
        mdr_we          = 1'b0;
        pc_we           = 1'b0;
        pc_src          = PC_SRC_SEQ;
        rf_we           = 1'b0;
        wb_sel          = WB_SEL_ALU;
        alu_src_a       = 1'b0;
        alu_src_b       = 1'b0;
        alu_use_dec     = 1'b0;
        halt_set        = 1'b0;
        illegal_set     = 1'b0;

        case (state)
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_we      = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!cls_valid || cls[CLS_SYSTEM]) begin
                    halt_set    = 1'b1;
                    illegal_set = !cls_valid;
                    state_next  = ST_HALT;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_a   = cls[CLS_AUIPC];
                alu_src_b   = !(cls[CLS_OP] || cls[CLS_BRANCH] || cls[CLS_JAL] || cls[CLS_MISC_MEM]);
                alu_use_dec = cls[CLS_OP] || cls[CLS_OP_IMM] || cls[CLS_BRANCH];
                if (cls[CLS_BRANCH] || cls[CLS_MISC_MEM]) begin
                    pc_we      = 1'b1;
                    pc_src     = (cls[CLS_BRANCH] && branch_taken) ? PC_SRC_BR : PC_SRC_SEQ;
                    state_next = ST_FETCH;
                end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem.mem_req     = 1'b1;
                mem.mem_is_data = 1'b1;
                mem.mem_we      = cls[CLS_STORE];
                if (mem.mem_ack) begin
                    if (cls[CLS_STORE]) begin
                        pc_we      = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        mdr_we     = 1'b1;
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                state_next = ST_FETCH;
                if (cls[CLS_LOAD]) wb_sel = WB_SEL_MEM;
                else if (cls[CLS_JAL] || cls[CLS_JALR]) wb_sel = WB_SEL_PC4;
                if (cls[CLS_JAL]) pc_src = PC_SRC_BR;
                else if (cls[CLS_JALR]) pc_src = PC_SRC_JALR;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase

        // Reset abandons any in-flight request and silences every enable
        if (rst) begin
            mem.mem_req     = 1'b0;
            mem.mem_we      = 1'b0;
            mem.mem_is_data = 1'b0;
            ir_we           = 1'b0;
            mdr_we          = 1'b0;
            pc_we           = 1'b0;
            pc_src          = PC_SRC_SEQ;
            rf_we           = 1'b0;
            wb_sel          = WB_SEL_ALU;
            alu_src_a       = 1'b0;
            alu_src_b       = 1'b0;
            alu_use_dec     = 1'b0;
            halt_set        = 1'b0;
            illegal_set     = 1'b0;
        end
        halted  = halted_q && !rst;
        illegal = illegal_q && !rst;
        instret = rst ? 32'd0 : instret_q;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. Steps each instruction through fetch, decode, execute, memory and writeback, driving the register-file, PC, IR and ALU-select enables of the shared datapath. Arbitrates the single unified memory port between instruction fetch and load/store. Sits between the instruction register and the datapath; the R/I-type decoders supply the operation-level `alu_op`, this block only chooses when and from where.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value the datapath loads on reset; passed through as `reset_pc`.
- `clk`  in  1  core clock
- `rst`  in  1  reset, synchronous and active-high; single clock domain
- `ir_opcode`  in  7  IR[6:0] of the latched instruction
- `branch_taken`  in  1  ALU compare result, valid in EXEC
- `mem_ack`  in  1  memory completed current request this cycle
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  1 = store
- `mem_is_data`  out  1  0 = instruction fetch (address from PC), 1 = data (address from ALU result)
- `ir_we`  out  1  latch instruction from memory read data
- `mdr_we`  out  1  latch load data
- `pc_we`  out  1  update PC
- `pc_src`  out  2  0 = PC+4, 1 = branch/JAL target (PC+imm), 2 = JALR target (ALU result with bit 0 cleared)
- `rf_we`  out  1  register-file write
- `wb_sel`  out  2  0 = ALU result, 1 = load data, 2 = PC+4
- `alu_src_a`  out  1  0 = rs1, 1 = PC
- `alu_src_b`  out  1  0 = rs2, 1 = immediate
- `alu_use_dec`  out  1  1 = ALU uses decoder `alu_op`, 0 = forced ADD
- `reset_pc`  out  32  constant `RESET_PC`
- `halted`  out  1  sticky; core stopped
- `illegal`  out  1  sticky; halt caused by unknown opcode
- `instret`  out  32  retired-instruction counter

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_is_data`=0. On `mem_ack`: `ir_we`=1, go DECODE. Otherwise stay.
- DECODE: one cycle, no enables. Classify `ir_opcode`: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, MISC-MEM 0001111, SYSTEM 1110011. Any other value: go HALT with `illegal`=1. SYSTEM: go HALT with `illegal`=0. All others: go EXEC.
- EXEC: ALU selects per class:
  - OP: a=rs1, b=rs2, dec=1
  - OP-IMM: a=rs1, b=imm, dec=1
  - LOAD/STORE/JALR: a=rs1, b=imm, dec=0
  - AUIPC: a=PC, b=imm, dec=0
  - LUI: datapath zeroes rs1; a=rs1, b=imm, dec=0
  - BRANCH: a=rs1, b=rs2, dec=1
- EXEC next state:
  - BRANCH: `pc_we`=1, `pc_src`=`branch_taken`?1:0, go FETCH.
  - MISC-MEM: `pc_we`=1, `pc_src`=0, go FETCH.
  - LOAD/STORE: go MEM.
  - All others: go WB.
- MEM: `mem_req`=1, `mem_is_data`=1, `mem_we`=1 for STORE. On `mem_ack`:
  - LOAD: `mdr_we`=1, go WB.
  - STORE: `pc_we`=1, `pc_src`=0, go FETCH.
- WB: `rf_we`=1, `pc_we`=1, go FETCH. By class:
  - `wb_sel`: LOAD 1, JAL/JALR 2, others 0.
  - `pc_src`: JAL 1, JALR 2, others 0.
- HALT: all enables 0, `mem_req`=0, absorbing until `rst`.
- `instret` += 1 on every cycle with `pc_we`=1; wraps 0xFFFF_FFFF→0.

## Timing
- Reset values: state FETCH, `instret`=0, `halted`=0, `illegal`=0, all enables and `mem_req`=0.
- During a cycle with `rst`=1, all outputs are gated to 0; `mem_req`=1 in the first cycle after reset release.
- Enables are combinational from registered state plus `mem_ack`/`branch_taken`. No enable is registered.
- `mem_ack` is ignored outside FETCH/MEM. `mem_req` stays asserted continuously across wait cycles. Address source (`mem_is_data`) never changes while `mem_req` is held.
- Latency with zero-wait memory (ack in the first request cycle):
  - BRANCH, MISC-MEM: 3 cycles
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
  - Each memory wait cycle adds 1.
- `rst` mid-MEM or mid-FETCH: request is abandoned; no `pc_we`, `rf_we` or `ir_we` in that cycle.
- `halted` and `illegal` are set on the DECODE→HALT edge, visible the next cycle.

## Structure
- Shared package `core_ctrl_pkg`:
  - state enum
  - opcode localparams
  - `pc_src` encodings
  - `wb_sel` encodings
- Natural sub-module `opcode_classify`: combinational, maps `ir_opcode` to a one-hot class plus a `valid` bit. It is reused by the hazard logic.
- The FSM and `instret` counter live in `multicycle_ctrl`.

## Test plan
- `ADD x3,x1,x2` (0x002081B3), ack immediate → FETCH,DECODE,EXEC,WB; a single `rf_we` pulse in cycle 4 with `wb_sel`=0; `instret`=1.
- `LW x3,0(x1)` (0x0000A183), fetch ack immediate, data ack after 3 wait cycles → `mem_req`/`mem_is_data` held 4 cycles; `mdr_we` on ack; WB with `wb_sel`=1; 8 cycles total.
- `BEQ x1,x2,+8` (0x00208463), `branch_taken`=1 → EXEC `pc_we`=1, `pc_src`=1; no `rf_we`; back in FETCH at cycle 4. With `branch_taken`=0 → `pc_src`=0.
- `JALR x1,0(x2)` (0x000100E7) → WB with `rf_we`=1, `wb_sel`=2, `pc_src`=2.
- Opcode 0x00000000 → HALT with `halted`=1, `illegal`=1. ECALL (0x00000073) → `halted`=1, `illegal`=0. In both cases `mem_req` stays 0 while `mem_ack` is toggled.
- `rst` asserted during a MEM wait of an SW (0x0020A023) → no `pc_we`; `instret` clears to 0; FETCH `mem_req` with `mem_is_data`=0 next cycle.
